// File: rtl/ps2_zx_keymatrix.sv
// PS/2 set-2 keyboard receiver that maintains the 40-key ZX Spectrum matrix.
// It also tracks F1 and F11 and answers port-#FE half-row reads on KEYB.
module ps2_zx_keymatrix #(
   parameter int unsigned FILT_LEN    = 8,
   parameter int unsigned TIMEOUT_CYC = 14000
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        PS2_CLK,
   input  logic        PS2_DAT,
   input  logic [15:0] A,
   output logic [4:0]  KEYB,
   output logic        F1,
   output logic        F11
);

   localparam int unsigned FILT_W   = $clog2(FILT_LEN + 1);
   localparam int unsigned TO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned NUM_KEYS = 44;
   localparam int unsigned KEY_W    = 6;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Matrix keys use index row*5+col; the others are extra shared keys, then F1 and F11.
   function automatic logic [KEY_W-1:0] key_idx(input logic [7:0] code);
      case (code)
         8'h12: key_idx = 6'd0;   8'h1A: key_idx = 6'd1;   8'h22: key_idx = 6'd2;
         8'h21: key_idx = 6'd3;   8'h2A: key_idx = 6'd4;   8'h1C: key_idx = 6'd5;
         8'h1B: key_idx = 6'd6;   8'h23: key_idx = 6'd7;   8'h2B: key_idx = 6'd8;
         8'h34: key_idx = 6'd9;   8'h15: key_idx = 6'd10;  8'h1D: key_idx = 6'd11;
         8'h24: key_idx = 6'd12;  8'h2D: key_idx = 6'd13;  8'h2C: key_idx = 6'd14;
         8'h16: key_idx = 6'd15;  8'h1E: key_idx = 6'd16;  8'h26: key_idx = 6'd17;
         8'h25: key_idx = 6'd18;  8'h2E: key_idx = 6'd19;  8'h45: key_idx = 6'd20;
         8'h46: key_idx = 6'd21;  8'h3E: key_idx = 6'd22;  8'h3D: key_idx = 6'd23;
         8'h36: key_idx = 6'd24;  8'h4D: key_idx = 6'd25;  8'h44: key_idx = 6'd26;
         8'h43: key_idx = 6'd27;  8'h3C: key_idx = 6'd28;  8'h35: key_idx = 6'd29;
         8'h5A: key_idx = 6'd30;  8'h4B: key_idx = 6'd31;  8'h42: key_idx = 6'd32;
         8'h3B: key_idx = 6'd33;  8'h33: key_idx = 6'd34;  8'h29: key_idx = 6'd35;
         8'h59: key_idx = 6'd36;  8'h3A: key_idx = 6'd37;  8'h31: key_idx = 6'd38;
         8'h32: key_idx = 6'd39;  8'h14: key_idx = 6'd40;  8'h66: key_idx = 6'd41;
         8'h05: key_idx = 6'd42;  8'h78: key_idx = 6'd43;
         default: key_idx = 6'd63;
      endcase
   endfunction

   logic              clk_meta, clk_sync, dat_meta, dat_sync;
   logic              clk_filt;
   logic [FILT_W-1:0] filt_cnt;
   logic              fall, bit_s;
   logic [TO_W-1:0]   to_cnt;
   logic              timeout;
   state_t            state, state_nxt;
   logic [7:0]        shift;
   logic [2:0]        bit_cnt;
   logic              par_ok;
   logic              byte_valid_c, frame_err_c;
   logic              rel, ext;
   logic [KEY_W-1:0]  idx;
   logic [NUM_KEYS-1:0] held;
   logic [39:0]       pressed;
   logic              unused_lo;

   assign unused_lo = ^A[7:0];

   // Two-stage synchronisers for both PS/2 lines
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= PS2_CLK;
         clk_sync <= clk_meta;
         dat_meta <= PS2_DAT;
         dat_sync <= dat_meta;
      end
   end

   // Accept a PS2_CLK level only after FILT_LEN consecutive differing samples
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
         bit_s    <= 1'b1;
      end else begin
         fall <= 1'b0;
         if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
            if (clk_filt) begin
               fall  <= 1'b1;
               bit_s <= dat_sync;
            end
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         to_cnt <= '0;
      end else if (fall || state == IDLE) begin
         to_cnt <= '0;
      end else if (to_cnt != TO_W'(TIMEOUT_CYC)) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC));

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (fall) begin
         case (state)
            IDLE:    if (!bit_s) state_nxt = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end else if (timeout && state != IDLE) begin
         state_nxt = IDLE;
      end
   end

   always_comb begin
      byte_valid_c = 1'b0;
      frame_err_c  = 1'b0;
      if (fall && state == STOP) begin
         if (bit_s && par_ok) byte_valid_c = 1'b1;
         else                 frame_err_c  = 1'b1;
      end
   end

   // Shift register, bit counter and odd-parity check
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         shift   <= '0;
         bit_cnt <= '0;
         par_ok  <= 1'b0;
      end else begin
         if (state == IDLE) bit_cnt <= '0;
         if (fall && state == DATA) begin
            shift   <= {bit_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (fall && state == PARITY) par_ok <= ^{bit_s, shift};
      end
   end

   assign idx = key_idx(shift);

   // Prefix flags and per-key held state
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         rel  <= 1'b0;
         ext  <= 1'b0;
         held <= '0;
      end else if (frame_err_c) begin
         rel <= 1'b0;
         ext <= 1'b0;
      end else if (byte_valid_c) begin
         if (shift == 8'hF0) begin
            rel <= 1'b1;
         end else if (shift == 8'hE0) begin
            ext <= 1'b1;
         end else begin
            if (!ext && idx < KEY_W'(NUM_KEYS)) held[idx] <= ~rel;
            rel <= 1'b0;
            ext <= 1'b0;
         end
      end
   end

   // Shared matrix bits read pressed while any contributing key is held
   always_comb begin
      pressed     = held[39:0];
      pressed[0]  = held[0]  | held[41];
      pressed[20] = held[20] | held[41];
      pressed[36] = held[36] | held[40];
   end

   always_comb begin
      KEYB = 5'h1F;
      for (int r = 0; r < 8; r++) begin
         if (!A[8+r]) begin
            for (int c = 0; c < 5; c++) begin
               if (pressed[r*5+c]) KEYB[c] = 1'b0;
            end
         end
      end
   end

   assign F1  = held[42];
   assign F11 = held[43];

endmodule

// File: tb/tb_ps2_zx_keymatrix.sv
// Scoreboard bench for ps2_zx_keymatrix: PS/2 frames in, half-row reads checked
// against expectations queued alongside the stimulus.
module tb_ps2_zx_keymatrix;

   localparam int unsigned HALF        = 20;
   localparam int unsigned TIMEOUT_CYC = 14000;

   logic        clk = 1'b0;
   logic        nreset;
   logic        ps2_clk;
   logic        ps2_dat;
   logic [15:0] a;
   logic [4:0]  keyb;
   logic        f1, f11;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [15:0] a;
      logic [4:0]  keyb;
      logic        f1;
      logic        f11;
   } exp_t;

   exp_t exp_q[$];

   ps2_zx_keymatrix #(.FILT_LEN(8), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .CLK     (clk),
      .nRESET  (nreset),
      .PS2_CLK (ps2_clk),
      .PS2_DAT (ps2_dat),
      .A       (a),
      .KEYB    (keyb),
      .F1      (f1),
      .F11     (f11)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_kb(input string tag, input logic [15:0] av, input logic [4:0] kb,
                            input logic e_f1, input logic e_f11);
      exp_t e;
      e.tag = tag; e.a = av; e.keyb = kb; e.f1 = e_f1; e.f11 = e_f11;
      exp_q.push_back(e);
   endtask

   // Apply each queued address and compare what the DUT returns
   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = e.a;
         @(negedge clk);
         check_eq({e.tag, ".keyb"}, 16'(keyb), 16'(e.keyb));
         check_eq({e.tag, ".f1"},   16'(f1),   16'(e.f1));
         check_eq({e.tag, ".f11"},  16'(f11),  16'(e.f11));
      end
   endtask

   task automatic ps2_frame(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = fr[i];
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      repeat (HALF) @(posedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      ps2_frame(b, 1'b0, 11);
   endtask

   initial begin
      nreset  = 1'b0;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      a       = 16'h0000;

      // Reset state
      repeat (3) @(posedge clk);
      expect_kb("reset", 16'h0000, 5'h1F, 1'b0, 1'b0);
      drain();
      nreset = 1'b1;
      repeat (5) @(posedge clk);

      // Basic make / break on A row
      send(8'h1C);
      expect_kb("a_press",     16'hFDFE, 5'h1E, 1'b0, 1'b0);
      expect_kb("a_all_rows",  16'h0000, 5'h1E, 1'b0, 1'b0);
      expect_kb("a_other_row", 16'hFEFE, 5'h1F, 1'b0, 1'b0);
      drain();
      send(8'hF0); send(8'h1C);
      expect_kb("a_release", 16'hFDFE, 5'h1F, 1'b0, 1'b0);
      drain();

      // Typematic repeat then a single break; release without press
      send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h1B);
      expect_kb("repeat_release", 16'hFDFE, 5'h1F, 1'b0, 1'b0);
      drain();

      // Backspace drives CapsShift and 0; LShift keeps CapsShift held
      send(8'h66); send(8'h12);
      expect_kb("bksp_zero", 16'hEFFE, 5'h1E, 1'b0, 1'b0);
      drain();
      send(8'hF0); send(8'h66);
      expect_kb("caps_shared",  16'hFEFE, 5'h1E, 1'b0, 1'b0);
      expect_kb("zero_release", 16'hEFFE, 5'h1F, 1'b0, 1'b0);
      drain();
      send(8'hF0); send(8'h12);
      expect_kb("lshift_release", 16'hFEFE, 5'h1F, 1'b0, 1'b0);
      drain();

      // SymbolShift shared by RShift and LCtrl
      send(8'h14);
      expect_kb("sym_lctrl", 16'h7FFE, 5'h1D, 1'b0, 1'b0);
      drain();
      send(8'h59); send(8'hF0); send(8'h14);
      expect_kb("sym_rshift", 16'h7FFE, 5'h1D, 1'b0, 1'b0);
      drain();
      send(8'hF0); send(8'h59);
      expect_kb("sym_release", 16'h7FFE, 5'h1F, 1'b0, 1'b0);
      drain();

      // Bad parity frame dropped, receiver recovers
      ps2_frame(8'h1C, 1'b1, 11);
      expect_kb("bad_parity", 16'hFDFE, 5'h1F, 1'b0, 1'b0);
      drain();
      send(8'h1C);
      expect_kb("after_bad", 16'hFDFE, 5'h1E, 1'b0, 1'b0);
      drain();
      send(8'hF0); send(8'h1C);

      // Partial frame aborted by timeout
      ps2_frame(8'h1C, 1'b0, 5);
      repeat (TIMEOUT_CYC + 10) @(posedge clk);
      send(8'h05);
      expect_kb("f1_press", 16'hFFFE, 5'h1F, 1'b1, 1'b0);
      drain();
      send(8'h78);
      expect_kb("f11_press", 16'hFFFE, 5'h1F, 1'b1, 1'b1);
      drain();
      send(8'hF0); send(8'h05);
      send(8'hF0); send(8'h78);
      expect_kb("f_release", 16'hFFFE, 5'h1F, 1'b0, 1'b0);
      drain();

      // Extended code ignored, flag cleared afterwards
      send(8'hE0); send(8'h12);
      expect_kb("ext_ignored", 16'hFEFE, 5'h1F, 1'b0, 1'b0);
      drain();
      send(8'h29); send(8'h16);
      expect_kb("multi_row", 16'h7EFE, 5'h1E, 1'b0, 1'b0);
      expect_kb("row_a11",   16'hF7FE, 5'h1E, 1'b0, 1'b0);
      expect_kb("no_rows",   16'hFFFE, 5'h1F, 1'b0, 1'b0);
      drain();

      // Reset in the middle of a frame
      send(8'h05);
      ps2_frame(8'h1C, 1'b0, 4);
      nreset = 1'b0;
      repeat (3) @(posedge clk);
      expect_kb("mid_reset", 16'h0000, 5'h1F, 1'b0, 1'b0);
      drain();
      nreset = 1'b1;
      repeat (5) @(posedge clk);
      send(8'h1C);
      expect_kb("post_reset", 16'hFDFE, 5'h1E, 1'b0, 1'b0);
      expect_kb("post_all",   16'h0000, 5'h1E, 1'b0, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
